rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Executes single RTC register accesses requested by the RTC sequencing FSM. It accepts a request made up of enable, read/write, address and data. It then performs the two-phase multiplexed address/data bus cycle on the RTC chip pins (CS#, RD#, WR#, A/D, AD[7:0]). It returns a one-cycle `out_flag_done`, which the requester uses to advance its step counter. Read data is delivered with its register address, so downstream display/config registers can capture it.

## Interface
Parameters:
- `PULSE_CYC`, default 4: clocks that CS# plus RD#/WR# stay low in each phase; must be ≥1.
- `GAP_CYC`, default 2: recovery clocks with all strobes high after each phase; must be ≥1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_en_funcion_rtc`  in  1  request valid; sampled only in IDLE.
- `in_funcion_w_r`  in  1  1 = write, 0 = read.
- `in_addr_ram_rtc`  in  8  RTC register address.
- `in_flag_inicio`  in  1  1 = write data comes from `in_dato_inicio`.
- `in_dato_inicio`  in  8  initialisation write data.
- `in_dato_escritura`  in  8  configuration write data, used when `in_flag_inicio`=0.
- `in_bus_dato`  in  8  AD bus input from the pad tristate.
- `out_bus_dato`  out  8  AD bus output value.
- `out_bus_oe`  out  1  AD pad output enable.
- `out_cs_n`, `out_rd_n`, `out_wr_n`  out  1 each  active-low chip strobes.
- `out_ad`  out  1  A/D select: 0 = address phase, 1 = data phase.
- `out_dato_leido`  out  8  last read data.
- `out_addr_leido`  out  8  address belonging to `out_dato_leido`.
- `out_flag_dato_valido`  out  1  one-cycle pulse when `out_dato_leido` updates.
- `out_flag_done`  out  1  one-cycle pulse when the transaction completes.

## Operation
- All outputs are registered.
- Reset values:
  - `out_cs_n`, `out_rd_n`, `out_wr_n`, `out_ad` = 1.
  - `out_bus_oe` = 0.
  - `out_bus_dato`, `out_dato_leido`, `out_addr_leido` = 0.
  - Both flags = 0.
  - State = IDLE, phase counter = 0.
- States: IDLE → ADDR_ACT → ADDR_REC → DATA_ACT → DATA_REC → DONE → IDLE.
- IDLE: if `in_en_funcion_rtc`=1, latch the request:
  - latch w_r and addr;
  - latch data = `in_flag_inicio` ? `in_dato_inicio` : `in_dato_escritura`;
  - go to ADDR_ACT with counter cleared.
- ADDR_ACT: `out_ad`=0, `out_bus_oe`=1, `out_bus_dato`=addr, `out_cs_n`=0, `out_wr_n`=0. This applies to reads as well as writes, because the address is always written.
- ADDR_REC: strobes high, address still driven (oe=1, ad=0).
- DATA_ACT:
  - Both directions: `out_ad`=1, `out_cs_n`=0.
  - Write: oe=1, bus=data, `out_wr_n`=0.
  - Read: oe=0, `out_rd_n`=0.
- DATA_REC: strobes high, `out_ad`=1.
  - Write: oe=1, data held.
  - Read: oe=0.
- DONE: strobes high, `out_ad`=1, oe=0, `out_flag_done`=1 for exactly this cycle.
  - Read only: `out_flag_dato_valido`=1 in the same cycle.
- Phase counter is 8 bits:
  - ACT states last `PULSE_CYC` cycles (counter 0..PULSE_CYC-1).
  - REC states last `GAP_CYC` cycles.
  - The counter clears on every state change.
- Read capture: `in_bus_dato` is registered into `out_dato_leido` at the edge that leaves DATA_ACT, i.e. the edge that raises RD#. `out_addr_leido` takes the latched addr at the same edge.
- Request inputs are ignored outside IDLE. Dropping `in_en_funcion_rtc` mid-transaction does not abort it; the transaction completes and pulses done.
- `out_bus_oe`=1 and `out_rd_n`=0 are never active in the same cycle.
- `out_rd_n` and `out_wr_n` are never both 0.

## Timing
- Let E0 be the edge that accepts the request (IDLE, en=1).
- With the defaults, CS# is low from E0 to E4 and from E6 to E10. Done is asserted by E12 and high for the one cycle E12–E13.
- General case:
  - first address-phase strobe: E0;
  - DATA_ACT entry: E(P+G);
  - done asserted: E(2P+2G);
  - where P=`PULSE_CYC` and G=`GAP_CYC`.
- After DONE there is always at least one IDLE cycle. The requester advances its counter on the done edge and presents the next address in that IDLE cycle, which is where it is sampled.
- Back-to-back requests (en held high) have a throughput of one transaction per 2P+2G+2 cycles.
- Reset asserted in any state: at the next edge all outputs return to reset values, the bus is released and the in-flight access is abandoned. No done pulse is generated.
- Reset and en high on the same edge: reset wins, and the request is not latched.

## Test plan
- Write 0x10 to addr 0x02 with `in_flag_inicio`=1 (defaults):
  - AD=0x02 with ad=0 and WR# low for cycles 0–3;
  - AD=0x10 with ad=1 and WR# low for cycles 6–9;
  - done pulses at cycle 12; `out_flag_dato_valido` stays 0.
- Write with `in_flag_inicio`=0, `in_dato_escritura`=0x59, `in_dato_inicio`=0xD2 to addr 0x21 → the data phase drives 0x59.
- Read addr 0xF0, bus model returns 0xA5 during RD# low:
  - oe=0 throughout DATA_ACT;
  - RD# low cycles 6–9;
  - at cycle 12: `out_dato_leido`=0xA5, `out_addr_leido`=0xF0, valid and done pulse together.
- Hold en high and step addr 0x21..0x27 on each done → seven transactions, each 14 cycles apart, each with the correct address on the bus.
- Assert reset in DATA_ACT of a write → next cycle CS#/WR# = 1, oe=0, no done. A new request afterward completes normally.
- Set P=1, G=1 and read 0x43 → done 4 cycles after accept, and data is captured correctly.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Executes one RTC register access on the multiplexed A/D bus: address phase, then data phase.
// Latency: bus activity starts on the accepting edge; done pulses 2*PULSE_CYC+2*GAP_CYC cycles later.
// Backpressure: requests are sampled only in IDLE; the requester holds en until the done pulse.
module rtc_bus_sequencer #(
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_en_funcion_rtc,
   input  logic       in_funcion_w_r,
   input  logic [7:0] in_addr_ram_rtc,
   input  logic       in_flag_inicio,
   input  logic [7:0] in_dato_inicio,
   input  logic [7:0] in_dato_escritura,
   input  logic [7:0] in_bus_dato,
   output logic [7:0] out_bus_dato,
   output logic       out_bus_oe,
   output logic       out_cs_n,
   output logic       out_rd_n,
   output logic       out_wr_n,
   output logic       out_ad,
   output logic [7:0] out_dato_leido,
   output logic [7:0] out_addr_leido,
   output logic       out_flag_dato_valido,
   output logic       out_flag_done
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR_ACT,
      ADDR_REC,
      DATA_ACT,
      DATA_REC,
      DONE
   } state_t;

   // Last count value of each phase; the counter runs 0..N-1 inside a state.
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

   state_t     state;
   logic [7:0] phase_cnt;
   logic       lat_w_r;
   logic [7:0] lat_addr;
   logic [7:0] lat_data;

   // Sequencer FSM; every output is set on the edge that enters the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= IDLE;
         phase_cnt            <= 8'd0;
         lat_w_r              <= 1'b0;
         lat_addr             <= 8'd0;
         lat_data             <= 8'd0;
         out_bus_dato         <= 8'd0;
         out_bus_oe           <= 1'b0;
         out_cs_n             <= 1'b1;
         out_rd_n             <= 1'b1;
         out_wr_n             <= 1'b1;
         out_ad               <= 1'b1;
         out_dato_leido       <= 8'd0;
         out_addr_leido       <= 8'd0;
         out_flag_dato_valido <= 1'b0;
         out_flag_done        <= 1'b0;
      end else begin
         out_flag_done        <= 1'b0;
         out_flag_dato_valido <= 1'b0;
         case (state)
            IDLE: begin
               if (in_en_funcion_rtc) begin
                  lat_w_r      <= in_funcion_w_r;
                  lat_addr     <= in_addr_ram_rtc;
                  lat_data     <= in_flag_inicio ? in_dato_inicio : in_dato_escritura;
                  state        <= ADDR_ACT;
                  phase_cnt    <= 8'd0;
                  // The address is always written, so WR# strobes even for reads.
                  out_ad       <= 1'b0;
                  out_bus_oe   <= 1'b1;
                  out_bus_dato <= in_addr_ram_rtc;
                  out_cs_n     <= 1'b0;
                  out_wr_n     <= 1'b0;
                  out_rd_n     <= 1'b1;
               end
            end
            ADDR_ACT: begin
               if (phase_cnt == PULSE_LAST) begin
                  state     <= ADDR_REC;
                  phase_cnt <= 8'd0;
                  out_cs_n  <= 1'b1;
                  out_wr_n  <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt + 8'd1;
               end
            end
            ADDR_REC: begin
               if (phase_cnt == GAP_LAST) begin
                  state     <= DATA_ACT;
                  phase_cnt <= 8'd0;
                  out_ad    <= 1'b1;
                  out_cs_n  <= 1'b0;
                  if (lat_w_r) begin
                     out_bus_oe   <= 1'b1;
                     out_bus_dato <= lat_data;
                     out_wr_n     <= 1'b0;
                  end else begin
                     // Release the pad before RD# falls so the chip can drive AD.
                     out_bus_oe <= 1'b0;
                     out_rd_n   <= 1'b0;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 8'd1;
               end
            end
            DATA_ACT: begin
               if (phase_cnt == PULSE_LAST) begin
                  state     <= DATA_REC;
                  phase_cnt <= 8'd0;
                  out_cs_n  <= 1'b1;
                  out_wr_n  <= 1'b1;
                  out_rd_n  <= 1'b1;
                  // Capture on the edge that raises RD#, while the chip still drives AD.
                  if (!lat_w_r) begin
                     out_dato_leido <= in_bus_dato;
                     out_addr_leido <= lat_addr;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 8'd1;
               end
            end
            DATA_REC: begin
               if (phase_cnt == GAP_LAST) begin
                  state                <= DONE;
                  phase_cnt            <= 8'd0;
                  out_bus_oe           <= 1'b0;
                  out_flag_done        <= 1'b1;
                  out_flag_dato_valido <= !lat_w_r;
               end else begin
                  phase_cnt <= phase_cnt + 8'd1;
               end
            end
            DONE: begin
               // Mandatory IDLE cycle follows so the requester can present the next request.
               state     <= IDLE;
               phase_cnt <= 8'd0;
            end
            default: begin
               state     <= IDLE;
               phase_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;

   localparam int P = 4;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, w_r, fi;
   logic [7:0] addr, di, de;
   logic [7:0] rd_val, junk;
   logic [7:0] bus_in;
   logic [7:0] bus_out, leido, addr_leido;
   logic       oe, cs_n, rd_n, wr_n, ad, valid, done;

   logic       en2, w_r2, fi2;
   logic [7:0] addr2, di2, de2, bus_in2;
   logic [7:0] bus_out2, leido2, addr_leido2;
   logic       oe2, cs_n2, rd_n2, wr_n2, ad2, valid2, done2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] rdv;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Chip model: drives the read value only while RD# is low, noise otherwise.
   assign bus_in  = rd_n ? junk : rd_val;
   assign bus_in2 = rd_n2 ? 8'h00 : 8'h3C;
   always @(negedge clk) junk <= 8'($urandom);

   rtc_bus_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
      .clk(clk), .reset(reset), .in_en_funcion_rtc(en), .in_funcion_w_r(w_r),
      .in_addr_ram_rtc(addr), .in_flag_inicio(fi), .in_dato_inicio(di),
      .in_dato_escritura(de), .in_bus_dato(bus_in), .out_bus_dato(bus_out),
      .out_bus_oe(oe), .out_cs_n(cs_n), .out_rd_n(rd_n), .out_wr_n(wr_n),
      .out_ad(ad), .out_dato_leido(leido), .out_addr_leido(addr_leido),
      .out_flag_dato_valido(valid), .out_flag_done(done)
   );

   rtc_bus_sequencer #(.PULSE_CYC(1), .GAP_CYC(1)) dut2 (
      .clk(clk), .reset(reset), .in_en_funcion_rtc(en2), .in_funcion_w_r(w_r2),
      .in_addr_ram_rtc(addr2), .in_flag_inicio(fi2), .in_dato_inicio(di2),
      .in_dato_escritura(de2), .in_bus_dato(bus_in2), .out_bus_dato(bus_out2),
      .out_bus_oe(oe2), .out_cs_n(cs_n2), .out_rd_n(rd_n2), .out_wr_n(wr_n2),
      .out_ad(ad2), .out_dato_leido(leido2), .out_addr_leido(addr_leido2),
      .out_flag_dato_valido(valid2), .out_flag_done(done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: observes the bus of each transaction and settles it against the queue on done.
   bit in_txn = 0;
   int start_cyc, a_cnt, a_wr, d_cnt, d_wr, d_rd, d_oe;
   logic [7:0] a_val, d_val;
   exp_t e;

   always @(negedge clk) begin
      if (reset) begin
         in_txn = 0;
      end else begin
         chk("oe_rd_excl", 32'(oe && !rd_n), 32'd0);
         chk("rd_wr_excl", 32'(!rd_n && !wr_n), 32'd0);
         chk("valid_wo_done", 32'(valid && !done), 32'd0);
         if (!cs_n && !in_txn) begin
            in_txn = 1; start_cyc = cyc;
            a_cnt = 0; a_wr = 0; d_cnt = 0; d_wr = 0; d_rd = 0; d_oe = 0;
            a_val = 8'h00; d_val = 8'h00;
         end
         if (!cs_n && !ad) begin
            a_cnt++; a_val = bus_out;
            if (oe && !wr_n && rd_n) a_wr++;
         end
         if (!cs_n && ad) begin
            d_cnt++; d_val = bus_out;
            if (!wr_n) d_wr++;
            if (!rd_n) d_rd++;
            if (oe) d_oe++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("latency", 32'(cyc - start_cyc), 32'(2*P + 2*G));
               chk("addr_cycles", 32'(a_cnt), 32'(P));
               chk("addr_wr_oe", 32'(a_wr), 32'(P));
               chk("addr_value", 32'(a_val), 32'(e.addr));
               chk("data_cycles", 32'(d_cnt), 32'(P));
               if (e.wr) begin
                  chk("wdata_value", 32'(d_val), 32'(e.data));
                  chk("wdata_wr", 32'(d_wr), 32'(P));
                  chk("wdata_oe", 32'(d_oe), 32'(P));
                  chk("wdata_rd", 32'(d_rd), 32'd0);
               end else begin
                  chk("rdata_rd", 32'(d_rd), 32'(P));
                  chk("rdata_oe", 32'(d_oe), 32'd0);
                  chk("rdata_wr", 32'(d_wr), 32'd0);
                  chk("rd_captured", 32'(leido), 32'(e.rdv));
                  chk("rd_addr", 32'(addr_leido), 32'(e.addr));
               end
               chk("valid_pulse", 32'(valid), 32'(!e.wr));
               chk("oe_at_done", 32'(oe), 32'd0);
            end
            in_txn = 0;
         end
      end
   end

   // Present a request, wait for the bus to start, then record what the chip must see.
   task automatic issue(input bit w, input logic [7:0] a, input bit f, input logic [7:0] d_i,
                        input logic [7:0] d_e, input logic [7:0] rv, input bit keep,
                        output int st);
      bit ok = 0;
      en = 1; w_r = w; addr = a; fi = f; di = d_i; de = d_e; rd_val = rv;
      st = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (!cs_n) ok = 1;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else begin
         exp_q.push_back('{wr: w, addr: a, data: (f ? d_i : d_e), rdv: rv});
         st = cyc;
      end
      if (!keep) begin
         // Request inputs must be ignored once the transaction runs.
         en = 0; w_r = 1'($urandom); addr = 8'($urandom);
         fi = 1'($urandom); di = 8'($urandom); de = 8'($urandom);
      end
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (done) ok = 1;
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   int st, prev_st;
   bit ok2;

   initial begin
      reset = 1; en = 1; w_r = 1; addr = 8'h55; fi = 1; di = 8'h11; de = 8'h22; rd_val = 8'h00;
      en2 = 0; w_r2 = 0; addr2 = 8'h00; fi2 = 0; di2 = 8'h00; de2 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      // Reset state, with a request held high during reset that must not be latched.
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_rd_n", 32'(rd_n), 32'd1);
      chk("rst_wr_n", 32'(wr_n), 32'd1);
      chk("rst_ad", 32'(ad), 32'd1);
      chk("rst_oe", 32'(oe), 32'd0);
      chk("rst_bus", 32'(bus_out), 32'd0);
      chk("rst_leido", 32'(leido), 32'd0);
      chk("rst_addr_leido", 32'(addr_leido), 32'd0);
      chk("rst_flags", 32'({valid, done}), 32'd0);
      en = 0; reset = 0;
      repeat (2) @(posedge clk);
      #1;

      // Directed accesses.
      issue(1, 8'h02, 1, 8'h10, 8'h77, 8'h00, 0, st); wait_done();
      issue(1, 8'h21, 0, 8'hD2, 8'h59, 8'h00, 0, st); wait_done();
      issue(0, 8'hF0, 0, 8'h00, 8'h00, 8'hA5, 0, st); wait_done();
      chk("read_leido_hold", 32'(leido), 32'hA5);

      // Randomized accesses with random idle gaps.
      for (int n = 0; n < 40; n++) begin
         issue(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 0, st);
         wait_done();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      // Back-to-back with en held; next address presented on each done.
      prev_st = 0;
      for (int k = 0; k < 7; k++) begin
         issue(1'(k % 2), 8'(8'h21 + k), 1, 8'(8'h80 + k), 8'h00, 8'(8'hC0 + k), (k < 6), st);
         if (k > 0) chk("b2b_spacing", 32'(st - prev_st), 32'(2*P + 2*G + 2));
         prev_st = st;
         wait_done();
      end

      // Reset in the data phase of a write abandons it without done.
      repeat (2) @(posedge clk);
      #1;
      issue(1, 8'h3A, 1, 8'hE7, 8'h00, 8'h00, 0, st);
      ok2 = 0;
      for (int i = 0; i < 40 && !ok2; i++) begin
         @(posedge clk); #1;
         if (!cs_n && ad) ok2 = 1;
      end
      if (!ok2) chk("reach_data_act", 32'd0, 32'd1);
      reset = 1;
      @(posedge clk); #1;
      chk("abort_cs_n", 32'(cs_n), 32'd1);
      chk("abort_wr_n", 32'(wr_n), 32'd1);
      chk("abort_oe", 32'(oe), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      reset = 0;
      void'(exp_q.pop_back());
      repeat (2*P + 2*G + 4) @(posedge clk);
      #1;
      issue(0, 8'h5B, 0, 8'h00, 8'h00, 8'h6E, 0, st); wait_done();

      // Minimum timing instance: read 0x43.
      en2 = 1; addr2 = 8'h43; w_r2 = 0;
      @(posedge clk); #1;
      chk("p1_accept", 32'(cs_n2), 32'd0);
      st = cyc; en2 = 0; addr2 = 8'hFF;
      ok2 = 0;
      for (int i = 0; i < 20 && !ok2; i++) begin
         @(posedge clk); #1;
         if (done2) ok2 = 1;
      end
      chk("p1_done_seen", 32'(ok2), 32'd1);
      chk("p1_latency", 32'(cyc - st), 32'd4);
      chk("p1_data", 32'(leido2), 32'h3C);
      chk("p1_addr", 32'(addr_leido2), 32'h43);
      chk("p1_valid", 32'(valid2), 32'd1);

      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
